// File: rtl/eth_rx_check.sv
// Ethernet receive frame checker: strips the FCS through a 4-byte delay line and
// reports CRC, length and destination-address status once per frame.
module eth_rx_check #(
    parameter logic [47:0] LOCAL_MAC = 48'h0012_3456_7890,
    parameter int          MIN_LEN   = 64,
    parameter int          MAX_LEN   = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_sof,
    input  logic        rx_eof,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eof,
    output logic        frame_done,
    output logic        frame_good,
    output logic        crc_err,
    output logic        len_err,
    output logic        addr_miss,
    output logic [15:0] frame_len,
    output logic [15:0] ethertype,
    output logic [15:0] cnt_good,
    output logic [15:0] cnt_bad
);

    localparam logic [15:0] MIN_L = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L = 16'(MAX_LEN);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    // MSB-first register with data bits fed LSB-first; FCS is its reflected complement
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[31] ^ data[i]) begin
                c = {c[30:0], 1'b0} ^ 32'h04C1_1DB7;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        r = 32'h0000_0000;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31 - i];
        end
        return r;
    endfunction

    function automatic logic [7:0] mac_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = LOCAL_MAC[47:40];
            3'd1:    b = LOCAL_MAC[39:32];
            3'd2:    b = LOCAL_MAC[31:24];
            3'd3:    b = LOCAL_MAC[23:16];
            3'd4:    b = LOCAL_MAC[15:8];
            3'd5:    b = LOCAL_MAC[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t      state_r, state_s;
    logic [15:0] len_r;
    logic [31:0] crc_r;
    logic [31:0] dly_r;
    logic [2:0]  cnt_r;
    logic        bc_r, lc_r;
    logic [15:0] et_r;

    logic        acc_s, emit_s, sof_out_s;
    logic [15:0] base_len_s, len_s, base_et_s, et_s;
    logic [31:0] base_crc_s, crc_s, base_dly_s, dly_s, fcs_s;
    logic [2:0]  base_cnt_s, cnt_s;
    logic        base_bc_s, base_lc_s, bc_s, lc_s, in_hdr_s;
    logic        crc_bad_s, len_bad_s, addr_bad_s, good_s;

    // Next-state logic: a start byte always (re)opens a frame, abort included
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rx_valid && rx_sof && !rx_eof) begin
                    state_s = ST_FRAME;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FRAME: begin
                if (rx_valid && rx_eof) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FRAME;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Per-byte datapath: rebase on sof, then advance length/CRC/delay line/header trackers
    always_comb begin
        acc_s      = rx_valid && (rx_sof || (state_r == ST_FRAME));
        base_len_s = rx_sof ? 16'd0 : len_r;
        base_crc_s = rx_sof ? 32'hFFFF_FFFF : crc_r;
        base_dly_s = rx_sof ? 32'h0000_0000 : dly_r;
        base_cnt_s = rx_sof ? 3'd0 : cnt_r;
        base_bc_s  = rx_sof ? 1'b1 : bc_r;
        base_lc_s  = rx_sof ? 1'b1 : lc_r;
        base_et_s  = rx_sof ? 16'h0000 : et_r;

        emit_s    = (base_cnt_s == 3'd4);
        sof_out_s = emit_s && (base_len_s == 16'd4);
        crc_s     = emit_s ? crc32_byte(base_crc_s, base_dly_s[31:24]) : base_crc_s;
        len_s     = (base_len_s == 16'hFFFF) ? 16'hFFFF : (base_len_s + 16'd1);
        dly_s     = {base_dly_s[23:0], rx_data};
        cnt_s     = emit_s ? 3'd4 : (base_cnt_s + 3'd1);

        in_hdr_s = (base_len_s < 16'd6);
        bc_s     = base_bc_s && (!in_hdr_s || (rx_data == 8'hFF));
        lc_s     = base_lc_s && (!in_hdr_s || (rx_data == mac_byte(base_len_s[2:0])));

        if (base_len_s == 16'd12) begin
            et_s = {rx_data, base_et_s[7:0]};
        end else if (base_len_s == 16'd13) begin
            et_s = {base_et_s[15:8], rx_data};
        end else begin
            et_s = base_et_s;
        end

        // Held bytes n-4..n-1; the first received FCS byte is FCS[7:0]
        fcs_s      = {rx_data, base_dly_s[7:0], base_dly_s[15:8], base_dly_s[23:16]};
        crc_bad_s  = (len_s < 16'd4) || (fcs_s != reflect32(~crc_s));
        len_bad_s  = (len_s < MIN_L) || (len_s > MAX_L);
        addr_bad_s = (len_s < 16'd6) || !(bc_s || lc_s);
        good_s     = !(crc_bad_s || len_bad_s || addr_bad_s);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Frame trackers, registered output stream, status and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            len_r      <= 16'd0;
            crc_r      <= 32'hFFFF_FFFF;
            dly_r      <= 32'h0000_0000;
            cnt_r      <= 3'd0;
            bc_r       <= 1'b0;
            lc_r       <= 1'b0;
            et_r       <= 16'h0000;
            out_data   <= 8'h00;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            frame_done <= 1'b0;
            frame_good <= 1'b0;
            crc_err    <= 1'b0;
            len_err    <= 1'b0;
            addr_miss  <= 1'b0;
            frame_len  <= 16'd0;
            ethertype  <= 16'h0000;
            cnt_good   <= 16'd0;
            cnt_bad    <= 16'd0;
        end else begin
            out_valid  <= acc_s && emit_s;
            out_sof    <= acc_s && sof_out_s;
            out_eof    <= acc_s && emit_s && rx_eof;
            frame_done <= acc_s && rx_eof;
            if (acc_s && emit_s) begin
                out_data <= base_dly_s[31:24];
            end
            if (acc_s && rx_eof) begin
                len_r      <= 16'd0;
                crc_r      <= 32'hFFFF_FFFF;
                dly_r      <= 32'h0000_0000;
                cnt_r      <= 3'd0;
                bc_r       <= 1'b0;
                lc_r       <= 1'b0;
                et_r       <= 16'h0000;
                frame_good <= good_s;
                crc_err    <= crc_bad_s;
                len_err    <= len_bad_s;
                addr_miss  <= addr_bad_s;
                frame_len  <= len_s;
                ethertype  <= (len_s >= 16'd14) ? et_s : 16'h0000;
                if (good_s) begin
                    cnt_good <= (cnt_good == 16'hFFFF) ? cnt_good : (cnt_good + 16'd1);
                end else begin
                    cnt_bad  <= (cnt_bad == 16'hFFFF) ? cnt_bad : (cnt_bad + 16'd1);
                end
            end else if (acc_s) begin
                len_r <= len_s;
                crc_r <= crc_s;
                dly_r <= dly_s;
                cnt_r <= cnt_s;
                bc_r  <= bc_s;
                lc_r  <= lc_s;
                et_r  <= et_s;
            end
        end
    end

endmodule

// File: doc/eth_rx_check.md
ETH_RX_CHECK -- requirements
Module: eth_rx_check

Interface
REQ-001 Parameter LOCAL_MAC, 48'h0012_3456_7890, station address accepted as destination besides broadcast.
REQ-002 Parameter MIN_LEN, 64, minimum legal frame length in bytes, FCS included.
REQ-003 Parameter MAX_LEN, 1518, maximum legal frame length in bytes, FCS included.
REQ-004 clk  in  1  single clock, the mac_rgmii RX byte clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 rx_data  in  8  frame byte from mac_rgmii; first byte is destination MAC byte 0, preamble/SFD already stripped.
REQ-007 rx_valid  in  1  rx_data valid this cycle; gaps allowed inside a frame.
REQ-008 rx_sof  in  1  qualified by rx_valid; first byte of frame.
REQ-009 rx_eof  in  1  qualified by rx_valid; last FCS byte of frame.
REQ-010 out_data  out  8  frame byte with FCS removed.
REQ-011 out_valid / out_sof / out_eof  out  1 each  output stream qualifiers.
REQ-012 frame_done  out  1  one-cycle pulse carrying per-frame status.
REQ-013 frame_good  out  1  valid with frame_done; no error flag set.
REQ-014 crc_err / len_err / addr_miss  out  1 each  valid with frame_done.
REQ-015 frame_len  out  16  bytes received incl. FCS, saturating at 16'hFFFF; valid with frame_done.
REQ-016 ethertype  out  16  bytes 12 (MSB) and 13; valid with frame_done, 0 if frame shorter than 14.
REQ-017 cnt_good / cnt_bad  out  16 each  saturating counts of good and bad completed frames.

Function
REQ-018 States IDLE and FRAME; IDLE->FRAME on rx_valid&rx_sof; FRAME->IDLE on rx_valid&rx_eof; bytes with rx_valid and no sof in IDLE ignored.
REQ-019 4-byte delay line of valid bytes; input byte k is presented on out_data with out_valid one clk after the rx_valid cycle of byte k+4; FCS bytes never output.
REQ-020 out_sof on output byte 0; out_eof on output byte n-5 (n = frame_len), asserted one clk after rx_eof, same cycle as frame_done.
REQ-021 CRC-32 (IEEE 802.3: poly 04C11DB7, init FFFFFFFF, LSB-first bits) runs over bytes leaving the delay line; at eof received FCS (four held bytes, first byte = FCS[7:0]) compared to ~CRC bit-reflected; mismatch -> crc_err.
REQ-022 len_err when frame_len < MIN_LEN or > MAX_LEN.
REQ-023 addr_miss when bytes 0..5 equal neither LOCAL_MAC nor FF:FF:FF:FF:FF:FF; frames shorter than 6 bytes set addr_miss.
REQ-024 frame_good = !(crc_err|len_err|addr_miss); downstream discards stream on !frame_good.
REQ-025 n <= 4: no output bytes, no out_eof; frame_done still pulses with len_err=1.
REQ-026 rx_sof and rx_eof in same valid cycle: 1-byte frame, frame_done with len_err=1, crc_err=1.
REQ-027 rx_sof while in FRAME: old frame aborted, no frame_done/out_eof for it, delay line flushed, new frame begins with this byte.
REQ-028 cnt_good increments on frame_done&frame_good, cnt_bad on frame_done&!frame_good; both hold at 16'hFFFF.
REQ-029 Status outputs hold last value between frame_done pulses.

Reset
REQ-030 rst gives: IDLE, delay line empty, CRC=FFFFFFFF, out_valid/out_sof/out_eof/frame_done=0, all status outputs and counters 0.
REQ-031 rst mid-frame discards the frame: no frame_done, no further output bytes; next rx_sof starts a fresh frame.

Verification
REQ-032 ARP request dst FF..FF, src E091F5B406B0, 42+18 pad bytes, correct FCS -> frame_good=1, frame_len=64, ethertype=16'h0806, 60 output bytes, cnt_good=1.
REQ-033 Same frame, FCS value +1 -> crc_err=1, frame_good=0, len/addr flags 0, cnt_bad=1.
REQ-034 Frame with dst 001DBA171DE7, correct FCS, 64 bytes -> addr_miss=1, crc_err=0, frame_good=0.
REQ-035 Single byte with rx_sof&rx_eof, then 3-byte frame -> two frame_done pulses, len_err=1, no out_valid.
REQ-036 rst asserted at byte 20 of good frame, then good broadcast frame -> only one frame_done, good, output starts at new byte 0.
REQ-037 rx_sof at byte 30 of a frame, new 64-byte good frame with 2-cycle valid gaps -> single frame_done, good, frame_len=64.
